gsau_wb_buffer: RTL and testbench

- Writeback buffer directly downstream of the GSAU control unit.
- Accepts partial-sum results (512-bit psum plus 8-bit destination vreg) over the wb_valid/wb_output_ready handshake and queues them in a small in-order FIFO.
- Drains the FIFO to the vector register file (Veggie file) write port and reports each completed writeback to the scoreboard so it can release the destination register.

---
 rtl/sys_arr_pkg.sv | 14 +
 rtl/sync_fifo.sv | 62 ++++++
 rtl/gsau_wb_buffer.sv | 93 +++++++++
 tb/tb_gsau_wb_buffer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// Shared systolic-array types: vector register word and writeback entry layout.
package sys_arr_pkg;

    localparam int VREG_W   = 512;
    localparam int WB_DEPTH = 4;

    typedef logic [VREG_W-1:0] vreg_t;

    typedef struct packed {
        vreg_t      psum;
        logic [7:0] dst;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic in-order FIFO; head is read straight from storage, no fall-through.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rptr_q];
    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/gsau_wb_buffer.sv
// GSAU writeback buffer: queues psum results, drains them to the Veggie file
// write port and reports each completed write to the scoreboard.
module gsau_wb_buffer
    import sys_arr_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int DATA_W = VREG_W,
    parameter int DST_W  = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [DATA_W-1:0] wb_psum,
    input  logic [DST_W-1:0]  wb_wbdst,
    input  logic              wb_valid,
    output logic              wb_output_ready,
    output logic              vrf_wen,
    output logic [DATA_W-1:0] vrf_wdata,
    output logic [DST_W-1:0]  vrf_wdst,
    input  logic              vrf_wready,
    output logic              sb_wb_done,
    output logic [DST_W-1:0]  sb_wb_dst,
    output logic              wb_empty,
    output logic              wb_overflow
);

    localparam int ENTRY_W = DATA_W + DST_W;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic               push, pop, stall;

    logic               done_q, done_d;
    logic [DST_W-1:0]   done_dst_q, done_dst_d;
    logic               ovf_q, ovf_d;
    logic               stall_q;
    logic [DST_W-1:0]   stall_dst_q;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (push),
        .wdata ({wb_psum, wb_wbdst}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // Ready depends only on registered occupancy, never on wb_valid.
    assign wb_output_ready = (fifo_count != CNT_W'(DEPTH));
    assign vrf_wen         = ~fifo_empty;
    assign wb_empty        = fifo_empty;
    assign vrf_wdata       = fifo_head[ENTRY_W-1:DST_W];
    assign vrf_wdst        = fifo_head[DST_W-1:0];

    assign push  = wb_valid & wb_output_ready;
    assign pop   = vrf_wen & vrf_wready;
    assign stall = wb_valid & fifo_full;

    assign sb_wb_done  = done_q;
    assign sb_wb_dst   = done_dst_q;
    assign wb_overflow = ovf_q;

    always_comb begin
        done_d     = pop;
        done_dst_d = pop ? vrf_wdst : done_dst_q;
        // An un-accepted offer must be held; a changed destination means it was not.
        ovf_d      = ovf_q | (stall_q & stall & (wb_wbdst != stall_dst_q));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            done_q      <= 1'b0;
            done_dst_q  <= '0;
            ovf_q       <= 1'b0;
            stall_q     <= 1'b0;
            stall_dst_q <= '0;
        end else begin
            done_q      <= done_d;
            done_dst_q  <= done_dst_d;
            ovf_q       <= ovf_d;
            stall_q     <= stall;
            stall_dst_q <= wb_wbdst;
        end
    end

endmodule

// File: tb/tb_gsau_wb_buffer.sv
// Directed self-checking bench for gsau_wb_buffer; inputs change and outputs are sampled on negedge.
module tb_gsau_wb_buffer;

    localparam int DW = 512;
    localparam int SW = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic [DW-1:0] wb_psum;
    logic [SW-1:0] wb_wbdst;
    logic          wb_valid;
    logic          wb_output_ready;
    logic          vrf_wen;
    logic [DW-1:0] vrf_wdata;
    logic [SW-1:0] vrf_wdst;
    logic          vrf_wready;
    logic          sb_wb_done;
    logic [SW-1:0] sb_wb_dst;
    logic          wb_empty;
    logic          wb_overflow;

    int n_chk  = 0;
    int n_fail = 0;
    logic [SW-1:0] got[$];

    always #5 CLK = ~CLK;

    gsau_wb_buffer dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .wb_psum         (wb_psum),
        .wb_wbdst        (wb_wbdst),
        .wb_valid        (wb_valid),
        .wb_output_ready (wb_output_ready),
        .vrf_wen         (vrf_wen),
        .vrf_wdata       (vrf_wdata),
        .vrf_wdst        (vrf_wdst),
        .vrf_wready      (vrf_wready),
        .sb_wb_done      (sb_wb_done),
        .sb_wb_dst       (sb_wb_dst),
        .wb_empty        (wb_empty),
        .wb_overflow     (wb_overflow)
    );

    always @(negedge CLK) begin
        if (nRST && sb_wb_done) got.push_back(sb_wb_dst);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic chk_got(input string tag, input int first, input int n);
        chk({tag, "_n"}, DW'(got.size()), DW'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            chk(tag, DW'(got[i]), DW'(first + i));
    endtask

    initial begin
        logic [DW-1:0] a5;
        bit pend;
        a5         = {64{8'hA5}};
        nRST       = 1'b0;
        wb_psum    = '0;
        wb_wbdst   = '0;
        wb_valid   = 1'b0;
        vrf_wready = 1'b0;
        #2;
        chk("rst_wen",   DW'(vrf_wen), 0);
        chk("rst_empty", DW'(wb_empty), 1);
        chk("rst_ready", DW'(wb_output_ready), 1);
        chk("rst_done",  DW'(sb_wb_done), 0);
        chk("rst_dst",   DW'(sb_wb_dst), 0);
        chk("rst_ovf",   DW'(wb_overflow), 0);
        cyc();
        nRST = 1'b1;

        // single entry, minimum latency
        cyc();
        wb_valid = 1; wb_wbdst = 8'd3; wb_psum = a5; vrf_wready = 1;
        cyc();
        wb_valid = 0;
        chk("t1_wen",   DW'(vrf_wen), 1);
        chk("t1_wdst",  DW'(vrf_wdst), 3);
        chk("t1_wdata", vrf_wdata, a5);
        chk("t1_done0", DW'(sb_wb_done), 0);
        cyc();
        chk("t1_done",  DW'(sb_wb_done), 1);
        chk("t1_sbdst", DW'(sb_wb_dst), 3);
        chk("t1_empty", DW'(wb_empty), 1);
        chk("t1_wen0",  DW'(vrf_wen), 0);
        cyc();
        chk("t1_pulse", DW'(sb_wb_done), 0);
        got.delete();

        // fill to full, hold a fifth offer, then drain in order
        vrf_wready = 0;
        for (int d = 1; d <= 4; d++) begin
            wb_valid = 1; wb_wbdst = SW'(d); wb_psum = {64{8'(d)}};
            cyc();
        end
        chk("t2_full",  DW'(wb_output_ready), 0);
        chk("t2_head",  DW'(vrf_wdst), 1);
        wb_wbdst = 8'd5; wb_psum = {64{8'd5}};
        cyc(); cyc(); cyc();
        chk("t2_ready_held", DW'(wb_output_ready), 0);
        chk("t2_ovf_stable", DW'(wb_overflow), 0);
        chk("t2_head_stable", vrf_wdata, {64{8'd1}});
        vrf_wready = 1;
        pend = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (pend) wb_valid = 0;
            pend = wb_valid && wb_output_ready;
        end
        chk_got("t2_order", 1, 5);
        chk("t2_empty", DW'(wb_empty), 1);
        got.delete();

        // steady stream, one in one out per cycle
        for (int i = 0; i < 16; i++) begin
            wb_valid = 1; wb_wbdst = SW'(i); wb_psum = {64{8'(i + 8'h40)}};
            cyc();
            chk("t3_wdst", DW'(vrf_wdst), DW'(i));
            chk("t3_ready", DW'(wb_output_ready), 1);
            if (i > 0) chk("t3_done", DW'(sb_wb_done), 1);
        end
        wb_valid = 0;
        cyc(); cyc(); cyc();
        chk_got("t3_order", 0, 16);
        got.delete();

        // simultaneous push and pop at count 2
        vrf_wready = 0;
        wb_valid = 1; wb_wbdst = 8'd20; cyc();
        wb_wbdst = 8'd21; cyc();
        wb_wbdst = 8'd22; vrf_wready = 1; cyc();
        wb_valid = 0; vrf_wready = 0;
        chk("t4_head",  DW'(vrf_wdst), 21);
        chk("t4_done",  DW'(sb_wb_done), 1);
        chk("t4_sbdst", DW'(sb_wb_dst), 20);
        vrf_wready = 1;
        cyc();
        chk("t4_head2", DW'(vrf_wdst), 22);
        chk("t4_wen2",  DW'(vrf_wen), 1);
        cyc();
        chk("t4_empty", DW'(wb_empty), 1);
        cyc();
        chk_got("t4_order", 20, 3);
        got.delete();

        // asynchronous reset with entries queued
        vrf_wready = 0;
        for (int d = 30; d < 33; d++) begin
            wb_valid = 1; wb_wbdst = SW'(d); cyc();
        end
        wb_valid = 0;
        vrf_wready = 1;
        #2 nRST = 0;
        #1;
        chk("t5_wen",   DW'(vrf_wen), 0);
        chk("t5_empty", DW'(wb_empty), 1);
        chk("t5_done",  DW'(sb_wb_done), 0);
        cyc();
        nRST = 1;
        cyc(); cyc(); cyc();
        chk("t5_wen_after", DW'(vrf_wen), 0);
        chk("t5_no_wb", DW'(got.size()), 0);
        got.delete();

        // protocol violation while full
        vrf_wready = 0;
        for (int d = 40; d < 44; d++) begin
            wb_valid = 1; wb_wbdst = SW'(d); cyc();
        end
        wb_wbdst = 8'd7; cyc();
        chk("t6_ovf_pre", DW'(wb_overflow), 0);
        wb_wbdst = 8'd8; cyc();
        chk("t6_ovf_set", DW'(wb_overflow), 1);
        wb_valid = 0; vrf_wready = 1;
        for (int k = 0; k < 6; k++) cyc();
        chk("t6_ovf_sticky", DW'(wb_overflow), 1);
        chk("t6_drained", DW'(wb_empty), 1);
        #2 nRST = 0;
        #1 chk("t6_ovf_rst", DW'(wb_overflow), 0);
        cyc();
        nRST = 1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
